vx_split_issue: RTL
===================

# vx_split_issue

Initiator side of the split/join protocol. Takes decoded SPLIT/JOIN requests from the SFU (per-thread predicate, active mask, next PC), forms the `split_t`/`join_t` payloads for the per-core split/join unit, and tracks per-warp nesting state. It waits for the unit's one-cycle-delayed join response and converts it into a thread-mask/PC update for warp control. Sits between the SFU warp-control path and the split/join unit, inside the core.

## Interface

- Parameters:
  - CORE_ID, 0, core index; unused except for debug.
  - THREAD_CNT, `NUM_THREADS`, threads per warp.
  - NEST_DEPTH, 2*THREAD_CNT, per-warp split nesting capacity, counting divergent and uniform splits.
- Ports:
  - clk, in, 1, clock.
  - reset, in, 1, synchronous, active-high.
  - req_valid, in, 1, request present.
  - req_ready, out, 1, request accepted when both valid and ready.
  - req_wid, in, `NW_WIDTH`, warp id.
  - req_is_join, in, 1, 1 = JOIN, 0 = SPLIT.
  - req_tmask, in, THREAD_CNT, active threads.
  - req_pred, in, THREAD_CNT, per-thread taken predicate.
  - req_next_pc, in, `XLEN`, PC of the else path.
  - valid, out, 1, payload to split/join unit.
  - wid, out, `NW_WIDTH`, payload warp.
  - split, out, split_t, split payload.
  - sjoin, out, join_t, join payload.
  - join_valid, join_is_dvg, join_is_else, in, 1 each, unit response.
  - join_wid, in, `NW_WIDTH`, response warp.
  - join_tmask, in, THREAD_CNT, response mask.
  - join_pc, in, `XLEN`, response PC.
  - wctl_valid, out, 1, warp-control update.
  - wctl_wid, out, `NW_WIDTH`, warp to update.
  - wctl_tmask, out, THREAD_CNT, new thread mask.
  - wctl_set_pc, out, 1, load wctl_pc.
  - wctl_pc, out, `XLEN`, new PC.
  - err, out, 1, sticky protocol error.

## Operation

- FSM: IDLE, WAIT_RSP.
  - req_ready = (state == IDLE).
- SPLIT accepted:
  - then = tmask & pred; else = tmask & ~pred; is_dvg = (then != 0) && (else != 0).
  - Registered outputs: valid=1, split.valid=1, split.is_dvg, split.then_tmask, split.else_tmask, split.next_pc = req_next_pc; sjoin.valid=0.
  - Push is_dvg onto the warp's bit stack.
  - Warp-control update, same cycle as the payload:
    - Divergent: wctl_tmask = then, wctl_set_pc = 0.
    - Uniform: wctl_tmask = tmask, wctl_set_pc = 0.
  - State stays IDLE.
- JOIN accepted:
  - Pop the warp's top bit into b.
  - Registered outputs: valid=1, sjoin.valid=1, sjoin.is_dvg=b; split.valid=0.
  - State → WAIT_RSP; latch wid and b.
- In WAIT_RSP, on join_valid:
  - join_is_dvg=0: wctl_valid, wctl_tmask = join_tmask, wctl_set_pc=0.
  - join_is_dvg=1, join_is_else=1: wctl_tmask = join_tmask, wctl_set_pc=1, wctl_pc = join_pc; re-push bit 1, because the else path reaches the same JOIN.
  - join_is_dvg=1, join_is_else=0: reconverged; wctl_tmask = join_tmask, wctl_set_pc=0.
  - All three cases return to IDLE.
- Boundaries:
  - Push at depth NEST_DEPTH: drop the bit, set err.
  - JOIN at depth 0: pop yields b=0, set err.
  - join_wid ≠ latched wid: set err; the response is still consumed.
  - join_valid while IDLE: ignored, set err.
  - Response in the same cycle a request arrives: the request waits, since ready is low in WAIT_RSP.
  - Re-push and pop on the same warp in the same cycle is impossible, because the FSM serializes them.

## Timing

- SPLIT accepted at T: payload and wctl at T+1. Next request can be accepted at T+1.
- JOIN accepted at T: payload at T+1, response expected at T+2, wctl at T+3. req_ready rises at T+3.
- All outputs are registered. Reset values: valid, split, sjoin, wctl_*, err = 0; req_ready = 1; state IDLE; all bit stacks empty.
- Reset mid-WAIT_RSP abandons the join. A late response after reset is ignored and sets err.

## Configuration

- SPLIT_ISSUE_CHECK_EN:
  - Defined: overflow, underflow, wid-mismatch and unexpected-response detection drive the sticky err; simulation asserts fire on each.
  - Undefined: err tied 0. Overflow pushes are dropped silently, underflow pops return 0, and response wid is not compared.

## Structure

- split_t and join_t stay in VX_gpu_pkg.
- Add to the package: the NEST_DEPTH default and a `dvg_depth_t` width, `$clog2(NEST_DEPTH+1)`.
- Sub-module vx_dvg_bitstack: one per warp, a LIFO of bits plus a depth counter, with push/pop/data/empty/full.

## Test plan

All scenarios use THREAD_CNT=4.

- SPLIT w0, tmask=4'b1111, pred=4'b0011, next_pc=0x100 → T+1: split.is_dvg=1, then=0011, else=1100; wctl_tmask=0011.
- Then JOIN w0 → sjoin.is_dvg=1. Drive response is_dvg=1, is_else=1, tmask=1100, pc=0x100 → wctl_set_pc=1, wctl_pc=0x100. Second JOIN → sjoin.is_dvg=1; response is_else=0, tmask=1111 → wctl_tmask=1111, depth 0.
- SPLIT w1, tmask=1010, pred=1010 → is_dvg=0. JOIN w1 → sjoin.is_dvg=0; response is_dvg=0, tmask=1010 → wctl_set_pc=0, no err.
- JOIN w2 with empty stack → sjoin.is_dvg=0 and err=1 (CHECK_EN defined); err=0 with it undefined.
- JOIN w3, response carries join_wid=2 → err=1 and state returns to IDLE. Assert reset while in WAIT_RSP → req_ready=1 next cycle; response at the following cycle → ignored, no wctl_valid.

Source files
------------

// File: rtl/vx_split_issue_pkg.sv
// Shared types and sizing for the split/join initiator: payload structs, FSM states,
// nesting-depth defaults.
package vx_split_issue_pkg;

  localparam int NUM_THREADS    = 4;
  localparam int NUM_WARPS      = 4;
  localparam int NW_WIDTH       = 2;
  localparam int XLEN           = 32;
  localparam int NEST_DEPTH_DEF = 2 * NUM_THREADS;
  localparam int DVG_DEPTH_W    = $clog2(NEST_DEPTH_DEF + 1);

  typedef logic [DVG_DEPTH_W-1:0] dvg_depth_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_dvg;
    logic [NUM_THREADS-1:0] then_tmask;
    logic [NUM_THREADS-1:0] else_tmask;
    logic [XLEN-1:0]        next_pc;
  } split_t;

  typedef struct packed {
    logic valid;
    logic is_dvg;
  } join_t;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_RSP = 1'b1
  } state_e;

endpackage

// File: rtl/vx_split_issue_if.sv
// Request channel from the SFU into the split/join initiator.
// A request transfers on a rising clk edge where req_valid && req_ready; the master
// holds all req_* fields stable while req_valid is high and ready is low.
interface vx_split_issue_if;
  import vx_split_issue_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [NW_WIDTH-1:0]    req_wid;
  logic                   req_is_join;
  logic [NUM_THREADS-1:0] req_tmask;
  logic [NUM_THREADS-1:0] req_pred;
  logic [XLEN-1:0]        req_next_pc;

  modport master (
    output req_valid, req_wid, req_is_join, req_tmask, req_pred, req_next_pc,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_wid, req_is_join, req_tmask, req_pred, req_next_pc,
    output req_ready
  );
endinterface

// File: rtl/vx_split_issue_bitstack.sv
// Per-warp divergence LIFO (vx_dvg_bitstack): one bit per nested split, top of stack in bits[0].
// Overflow pushes and underflow pops are ignored; data reads 0 when empty.
module vx_dvg_bitstack
  import vx_split_issue_pkg::*;
#(
  parameter int DEPTH = NEST_DEPTH_DEF
)(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic push_bit,
  output logic data,
  output logic empty,
  output logic full
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] bits;
  logic [DW-1:0]    cnt;

  assign empty = (cnt == '0);
  assign full  = (cnt == DW'(DEPTH));
  // Pops shift zeros in from the top, so an empty stack always reads 0.
  assign data  = bits[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      bits <= '0;
      cnt  <= '0;
    end else if (push && !full) begin
      bits <= {bits[DEPTH-2:0], push_bit};
      cnt  <= cnt + 1'b1;
    end else if (pop && !empty) begin
      bits <= {1'b0, bits[DEPTH-1:1]};
      cnt  <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/vx_split_issue.sv
// Split/join initiator: forms split/join payloads, tracks per-warp nesting bits and turns
// join responses into warp-control updates. SPLIT_ISSUE_CHECK_EN enables the sticky err.
module vx_split_issue
  import vx_split_issue_pkg::*;
#(
  parameter int CORE_ID    = 0,
  parameter int THREAD_CNT = NUM_THREADS,
  parameter int NEST_DEPTH = 2 * THREAD_CNT
)(
  input  logic                  clk,
  input  logic                  reset,
  vx_split_issue_if.slave       req,
  output logic                  valid,
  output logic [NW_WIDTH-1:0]   wid,
  output split_t                split,
  output join_t                 sjoin,
  input  logic                  join_valid,
  input  logic                  join_is_dvg,
  input  logic                  join_is_else,
  input  logic [NW_WIDTH-1:0]   join_wid,
  input  logic [THREAD_CNT-1:0] join_tmask,
  input  logic [XLEN-1:0]       join_pc,
  output logic                  wctl_valid,
  output logic [NW_WIDTH-1:0]   wctl_wid,
  output logic [THREAD_CNT-1:0] wctl_tmask,
  output logic                  wctl_set_pc,
  output logic [XLEN-1:0]       wctl_pc,
  output logic                  err,
  output state_e                dbg_state
);
  localparam int unused_core_id = CORE_ID;

  state_e                state, state_n;
  logic [NW_WIDTH-1:0]   lat_wid;
  logic [NUM_WARPS-1:0]  push_vec, pop_vec, top_v, empty_v, full_v;
  logic                  push_bit, req_fire, is_dvg, pop_bit;
  logic [THREAD_CNT-1:0] then_m, else_m;

  assign dbg_state     = state;
  assign req.req_ready = (state == ST_IDLE);
  assign req_fire      = req.req_valid && (state == ST_IDLE);
  assign then_m        = req.req_tmask & req.req_pred;
  assign else_m        = req.req_tmask & ~req.req_pred;
  assign is_dvg        = (then_m != '0) && (else_m != '0);
  assign pop_bit       = top_v[req.req_wid];

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_stack
    vx_dvg_bitstack #(.DEPTH(NEST_DEPTH)) u_stack (
      .clk(clk), .reset(reset), .push(push_vec[g]), .pop(pop_vec[g]),
      .push_bit(push_bit), .data(top_v[g]), .empty(empty_v[g]), .full(full_v[g])
    );
  end

  always_comb begin
    state_n  = state;
    push_vec = '0;
    pop_vec  = '0;
    push_bit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_fire && req.req_is_join) begin
          pop_vec[req.req_wid] = 1'b1;
          state_n              = ST_WAIT_RSP;
        end else if (req_fire) begin
          push_vec[req.req_wid] = 1'b1;
          push_bit              = is_dvg;
        end
      end
      ST_WAIT_RSP: begin
        if (join_valid) begin
          state_n = ST_IDLE;
          // The else path will hit the same JOIN again, so its divergence bit comes back.
          if (join_is_dvg && join_is_else) begin
            push_vec[lat_wid] = 1'b1;
            push_bit          = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      lat_wid     <= '0;
      valid       <= 1'b0;
      wid         <= '0;
      split       <= '0;
      sjoin       <= '0;
      wctl_valid  <= 1'b0;
      wctl_wid    <= '0;
      wctl_tmask  <= '0;
      wctl_set_pc <= 1'b0;
      wctl_pc     <= '0;
    end else begin
      state       <= state_n;
      valid       <= 1'b0;
      split       <= '0;
      sjoin       <= '0;
      wctl_valid  <= 1'b0;
      wctl_set_pc <= 1'b0;
      if (req_fire && !req.req_is_join) begin
        valid      <= 1'b1;
        wid        <= req.req_wid;
        split      <= '{valid: 1'b1, is_dvg: is_dvg, then_tmask: then_m,
                        else_tmask: else_m, next_pc: req.req_next_pc};
        wctl_valid <= 1'b1;
        wctl_wid   <= req.req_wid;
        wctl_tmask <= is_dvg ? then_m : req.req_tmask;
      end
      if (req_fire && req.req_is_join) begin
        valid   <= 1'b1;
        wid     <= req.req_wid;
        sjoin   <= '{valid: 1'b1, is_dvg: pop_bit};
        lat_wid <= req.req_wid;
      end
      if (state == ST_WAIT_RSP && join_valid) begin
        wctl_valid  <= 1'b1;
        wctl_wid    <= lat_wid;
        wctl_tmask  <= join_tmask;
        wctl_set_pc <= join_is_dvg && join_is_else;
        wctl_pc     <= join_pc;
      end
    end
  end

`ifdef SPLIT_ISSUE_CHECK_EN
  logic overflow, underflow, wid_mismatch, stray_rsp;
  assign overflow     = |(push_vec & full_v);
  assign underflow    = |(pop_vec & empty_v);
  assign wid_mismatch = (state == ST_WAIT_RSP) && join_valid && (join_wid != lat_wid);
  assign stray_rsp    = (state == ST_IDLE) && join_valid;

  always_ff @(posedge clk) begin
    if (reset)
      err <= 1'b0;
    else if (overflow || underflow || wid_mismatch || stray_rsp)
      err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!overflow)     else $warning("split_issue: nesting stack overflow");
      assert (!underflow)    else $warning("split_issue: join on empty nesting stack");
      assert (!wid_mismatch) else $warning("split_issue: join response warp differs");
      assert (!stray_rsp)    else $warning("split_issue: join response while idle");
    end
  end
`else
  logic unused_check;
  assign err          = 1'b0;
  assign unused_check = ^{full_v, empty_v, join_wid};
`endif
endmodule
